// File: rtl/led_pkg.sv
// Shared constants and state encoding for the LED frame feeder and the
// serial shift-register controller it drives.
package led_pkg;

   localparam int NUM_STRIPS      = 8;
   localparam int BITS_PER_LED    = 24;
   localparam int CLKS_PER_SYMBOL = 24;
   localparam int LATCH_SYMBOLS   = 48;

   // The controller reuses this encoding for its phase counter.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      LATCH = 2'b10
   } led_state_t;

endpackage

// File: rtl/led_pix_buf.sv
// Two-entry pixel buffer: one active word being shifted out and one
// holding word. The FSM pops holding into active on load boundaries.
// When pop arrives with holding empty, the pixel accepted on that same
// edge goes straight into active.
module led_pix_buf
   import led_pkg::*;
#(
   parameter int PIX_W = NUM_STRIPS * BITS_PER_LED
) (
   input  logic             clk,
   input  logic             ar,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             pix_last,
   input  logic             pix_valid,
   output logic             pix_ready,
   input  logic             pop,
   output logic             hold_full,
   output logic [PIX_W-1:0] act_data,
   output logic             act_last
);

   logic             hold_vld;
   logic [PIX_W-1:0] hold_data;
   logic             hold_last;
   logic             push;
   logic             bypass;

   assign pix_ready = !hold_vld || pop;
   assign push      = pix_valid && pix_ready;
   assign bypass    = pop && !hold_vld;
   assign hold_full = hold_vld;

   // Holding occupancy; a simultaneous pop and push keeps holding full.
   always_ff @(posedge clk or negedge ar) begin
      if (!ar) begin
         hold_vld <= 1'b0;
      end else if (pop) begin
         hold_vld <= push && hold_vld;
      end else if (push) begin
         hold_vld <= 1'b1;
      end
   end

   // Pixel words carry no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push && !bypass) begin
         hold_data <= pix_data;
         hold_last <= pix_last;
      end
      if (pop) begin
         act_data <= hold_vld ? hold_data : pix_data;
         act_last <= hold_vld ? hold_last : pix_last;
      end
   end

endmodule

// File: rtl/led_frame_feeder.sv
// Feeds one pixel word per LED to the serial LED controller, one colour
// bit per symbol period on all strips in parallel, MSB first, and inserts
// the blanked latch period after the last LED of each frame.
module led_frame_feeder
   import led_pkg::*;
#(
   parameter int NUM_STRIPS      = led_pkg::NUM_STRIPS,
   parameter int BITS_PER_LED    = led_pkg::BITS_PER_LED,
   parameter int CLKS_PER_SYMBOL = led_pkg::CLKS_PER_SYMBOL,
   parameter int LATCH_SYMBOLS   = led_pkg::LATCH_SYMBOLS
) (
   input  logic                               sr_clk,
   input  logic                               ar,
   input  logic [NUM_STRIPS*BITS_PER_LED-1:0] pix_data,
   input  logic                               pix_last,
   input  logic                               pix_valid,
   output logic                               pix_ready,
   output logic [NUM_STRIPS-1:0]              data_out,
   output logic                               blank,
   output logic                               frame_done,
   output logic                               underrun
);

   localparam int PIX_W = NUM_STRIPS * BITS_PER_LED;
   localparam int SYM_W = (CLKS_PER_SYMBOL > 1) ? $clog2(CLKS_PER_SYMBOL) : 1;
   localparam int BIT_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
   localparam int LAT_W = $clog2(LATCH_SYMBOLS + 1);

   led_state_t       state;
   led_state_t       state_nxt;
   logic [SYM_W-1:0] sym_cnt;
   logic             boundary;
   logic [BIT_W-1:0] bit_idx;
   logic [BIT_W-1:0] bit_nxt;
   logic [LAT_W-1:0] lat_cnt;
   logic [LAT_W-1:0] lat_nxt;
   logic             pop;
   logic             set_underrun;
   logic             done_nxt;
   logic             hold_full;
   logic [PIX_W-1:0] act_data;
   logic             act_last;

   // Gather bit idx of every strip's colour word into one bus word.
   function automatic logic [NUM_STRIPS-1:0] strip_bits(
      input logic [PIX_W-1:0] word,
      input logic [BIT_W-1:0] idx
   );
      logic [NUM_STRIPS-1:0] bits;
      int                    pos;
      bits = '0;
      for (int s = 0; s < NUM_STRIPS; s++) begin
         pos     = s * BITS_PER_LED + int'(idx);
         bits[s] = word[pos];
      end
      return bits;
   endfunction

   led_pix_buf #(
      .PIX_W (PIX_W)
   ) u_buf (
      .clk       (sr_clk),
      .ar        (ar),
      .pix_data  (pix_data),
      .pix_last  (pix_last),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pop       (pop),
      .hold_full (hold_full),
      .act_data  (act_data),
      .act_last  (act_last)
   );

   assign boundary = (sym_cnt == SYM_W'(CLKS_PER_SYMBOL - 1));

   // Free-running symbol phase counter, aligned with the controller by ar.
   always_ff @(posedge sr_clk or negedge ar) begin
      if (!ar) begin
         sym_cnt <= '0;
      end else if (boundary) begin
         sym_cnt <= '0;
      end else begin
         sym_cnt <= sym_cnt + 1'b1;
      end
   end

   // State, counters and status flags; everything moves on symbol boundaries.
   always_ff @(posedge sr_clk or negedge ar) begin
      if (!ar) begin
         state      <= IDLE;
         bit_idx    <= '0;
         lat_cnt    <= '0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_idx    <= bit_nxt;
         lat_cnt    <= lat_nxt;
         frame_done <= done_nxt;
         if (set_underrun) begin
            underrun <= 1'b1;
         end
      end
   end

   // Next-state decisions and symbol outputs.
   always_comb begin
      state_nxt    = state;
      bit_nxt      = bit_idx;
      lat_nxt      = lat_cnt;
      pop          = 1'b0;
      set_underrun = 1'b0;
      done_nxt     = 1'b0;
      blank        = 1'b1;
      data_out     = '0;

      if (state == SHIFT) begin
         blank    = 1'b0;
         data_out = strip_bits(act_data, bit_idx);
      end

      if (boundary) begin
         case (state)
            IDLE: begin
               if (hold_full) begin
                  pop       = 1'b1;
                  bit_nxt   = BIT_W'(BITS_PER_LED - 1);
                  state_nxt = SHIFT;
               end
            end
            SHIFT: begin
               if (bit_idx == '0) begin
                  if (act_last) begin
                     lat_nxt   = '0;
                     state_nxt = LATCH;
                  end else if (hold_full || pix_valid) begin
                     // A pixel arriving on this very edge still counts.
                     pop     = 1'b1;
                     bit_nxt = BIT_W'(BITS_PER_LED - 1);
                  end else begin
                     set_underrun = 1'b1;
                     state_nxt    = IDLE;
                  end
               end else begin
                  bit_nxt = bit_idx - 1'b1;
               end
            end
            LATCH: begin
               if (lat_cnt == LAT_W'(LATCH_SYMBOLS - 1)) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  lat_nxt = lat_cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_frame_feeder.sv
// Randomized bench for led_frame_feeder with a symbol-level reference model.
module tb_led_frame_feeder;

   localparam int NS = 8;
   localparam int BP = 24;
   localparam int CS = 24;
   localparam int LS = 48;
   localparam int PW = NS * BP;

   logic          sr_clk = 1'b0;
   logic          ar     = 1'b0;
   logic [PW-1:0] pix_data  = '0;
   logic          pix_last  = 1'b0;
   logic          pix_valid = 1'b0;
   logic          pix_ready;
   logic [NS-1:0] data_out;
   logic          blank;
   logic          frame_done;
   logic          underrun;

   int checks   = 0;
   int failures = 0;

   led_frame_feeder dut (
      .sr_clk     (sr_clk),
      .ar         (ar),
      .pix_data   (pix_data),
      .pix_last   (pix_last),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .data_out   (data_out),
      .blank      (blank),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   initial forever #5 sr_clk = ~sr_clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (symbol level) ----------------
   // mode: 0 blank/idle, 1 sending an LED, 2 latch blanking
   logic [PW:0]   q[$];          // accepted pixels not yet started {last, data}
   int            m_mode = 0;
   logic [PW-1:0] m_cur  = '0;
   logic          m_cur_last = 1'b0;
   int            m_bit = 0;
   int            m_lat = 0;
   int            m_sym = 0;
   bit            m_ur  = 0;
   bit            m_fd  = 0;
   longint        cyc   = 0;

   function automatic logic [NS-1:0] m_strip(input logic [PW-1:0] w, input int b);
      logic [NS-1:0] r;
      for (int s = 0; s < NS; s++) r[s] = w[s*BP + b];
      return r;
   endfunction

   // Whether the model can take a pixel this cycle: a free slot, or the
   // waiting pixel is about to start on this symbol edge.
   function automatic bit m_ready();
      bit starting;
      starting = (m_sym == CS-1) &&
                 (m_mode == 0 || (m_mode == 1 && m_bit == 0 && !m_cur_last));
      return (q.size() == 0) || starting;
   endfunction

   initial forever begin
      @(posedge sr_clk or negedge ar);
      if (!ar) begin
         q.delete();
         m_mode = 0; m_bit = 0; m_lat = 0; m_sym = 0; m_ur = 0; m_fd = 0;
      end else begin
         bit acc, idle_avail;
         acc        = pix_valid && m_ready();
         idle_avail = q.size() > 0;
         if (acc) q.push_back({pix_last, pix_data});
         m_fd = 0;
         cyc++;
         if (m_sym == CS-1) begin
            if (m_mode == 0) begin
               if (idle_avail) begin
                  {m_cur_last, m_cur} = q.pop_front();
                  m_mode = 1; m_bit = BP-1;
               end
            end else if (m_mode == 1) begin
               if (m_bit > 0) m_bit--;
               else if (m_cur_last) begin m_mode = 2; m_lat = 0; end
               else if (q.size() > 0) begin
                  {m_cur_last, m_cur} = q.pop_front();
                  m_bit = BP-1;
               end else begin
                  m_ur = 1; m_mode = 0;
               end
            end else begin
               if (m_lat == LS-1) begin m_mode = 0; m_fd = 1; end
               else m_lat++;
            end
         end
         m_sym = (m_sym + 1) % CS;
      end
   end

   // ---------------- continuous comparison ----------------
   longint start_cyc = 0;
   longint fd_cyc    = 0;
   int     fd_cnt    = 0;
   logic   prev_blank = 1'b1;

   initial forever begin
      @(negedge sr_clk);
      if (ar) begin
         check_eq("data_out",   data_out,   (m_mode == 1) ? m_strip(m_cur, m_bit) : '0);
         check_eq("blank",      blank,      m_mode != 1);
         check_eq("pix_ready",  pix_ready,  m_ready());
         check_eq("frame_done", frame_done, m_fd);
         check_eq("underrun",   underrun,   m_ur);
         if (prev_blank && !blank) start_cyc = cyc;
         if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
         prev_blank = blank;
      end else begin
         prev_blank = 1'b1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [PW-1:0] d, input logic l);
      int n;
      bit rdy;
      pix_data = d; pix_last = l; pix_valid = 1'b1;
      n = 0;
      forever begin
         #1 rdy = pix_ready;
         @(negedge sr_clk);
         if (rdy || n > 4000) break;
         n++;
      end
      check_eq("send_accept", rdy, 1'b1);
      pix_valid = 1'b0;
   endtask

   task automatic wait_fd(input int target, input int bound);
      int n;
      n = 0;
      while (fd_cnt < target && n < bound) begin
         @(negedge sr_clk);
         n++;
      end
      check_eq("fd_wait", fd_cnt >= target, 1'b1);
   endtask

   task automatic wait_start(input int bound);
      int n;
      n = 0;
      while (blank && n < bound) begin
         @(negedge sr_clk);
         n++;
      end
      check_eq("start_wait", blank, 1'b0);
   endtask

   function automatic logic [PW-1:0] rand_pix();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [PW-1:0] d;
      int base, nfr, nled, gap;

      repeat (3) @(negedge sr_clk);
      ar = 1'b1;
      @(negedge sr_clk);
      check_eq("rst_blank", blank, 1'b1);
      check_eq("rst_data", data_out, '0);
      check_eq("rst_ready", pix_ready, 1'b1);
      check_eq("rst_ur", underrun, 1'b0);

      // idle for 100 cycles
      repeat (100) @(negedge sr_clk);
      check_eq("idle_fd_cnt", fd_cnt, 0);

      // one LED, every strip 0xA500FF
      base = fd_cnt;
      send({NS{24'hA500FF}}, 1'b1);
      wait_fd(base + 1, 3000);
      check_eq("one_led_fd_lat", fd_cyc - start_cyc, 64'd1728);
      repeat (30) @(negedge sr_clk);
      check_eq("one_led_fd_once", fd_cnt, base + 1);

      // four LEDs back to back, strip s = s*0x010101
      base = fd_cnt;
      for (int i = 0; i < 4; i++) begin
         for (int s = 0; s < NS; s++) d[s*BP +: BP] = 24'(s * 24'h010101) ^ 24'(i);
         send(d, i == 3);
      end
      wait_fd(base + 1, 6000);
      check_eq("b2b_no_ur", underrun, 1'b0);

      // underrun: second LED withheld past the first LED's last boundary
      base = fd_cnt;
      send(rand_pix(), 1'b0);
      repeat (24*26 + 30) @(negedge sr_clk);
      check_eq("ur_set", underrun, 1'b1);
      send(rand_pix(), 1'b1);
      wait_fd(base + 1, 3000);
      check_eq("ur_sticky", underrun, 1'b1);

      // pixels offered during the latch period
      base = fd_cnt;
      send(rand_pix(), 1'b1);
      wait_start(100);
      repeat (24*24 + 10) @(negedge sr_clk);
      send(rand_pix(), 1'b1);
      check_eq("latch_ready_drop", pix_ready, 1'b0);
      send(rand_pix(), 1'b1);
      @(negedge sr_clk);
      check_eq("latch_restart", start_cyc - fd_cyc, 64'd24);
      wait_fd(base + 3, 6000);

      // random frames with random gaps
      base = fd_cnt;
      nfr  = 6;
      for (int f = 0; f < nfr; f++) begin
         nled = $urandom_range(1, 4);
         for (int i = 0; i < nled; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 700) : 0;
            repeat (gap) @(negedge sr_clk);
            send(rand_pix(), i == nled - 1);
         end
      end
      wait_fd(base + nfr, 20000);

      // asynchronous reset in the middle of a shifting symbol
      send(rand_pix(), 1'b0);
      send(rand_pix(), 1'b1);
      repeat (100) @(negedge sr_clk);
      check_eq("pre_rst_ur", underrun, 1'b1);
      @(posedge sr_clk);
      #3 ar = 1'b0;
      #1;
      check_eq("arst_data", data_out, '0);
      check_eq("arst_blank", blank, 1'b1);
      check_eq("arst_ready", pix_ready, 1'b1);
      check_eq("arst_fd", frame_done, 1'b0);
      check_eq("arst_ur", underrun, 1'b0);
      repeat (2) @(negedge sr_clk);
      ar = 1'b1;
      base = fd_cnt;
      repeat (7) @(negedge sr_clk);
      send(rand_pix(), 1'b1);
      wait_fd(base + 1, 3000);
      check_eq("post_rst_ur", underrun, 1'b0);

      repeat (10) @(negedge sr_clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Overall time bound.
   initial begin
      #1500000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/led_frame_feeder.md
# led_frame_feeder

- Upstream neighbour of the serial LED shift-register controller.
- Accepts one pixel word per LED index: a 24-bit colour for each of the parallel strips. Sends those pixels one bit per symbol period on an 8-bit `data_out` bus, which drives the controller's `data_in`.
- Keeps `data_out` stable for each full three-phase symbol.
- After the last LED of a frame, inserts the blanked latch period that the strips need.

## Interface

Parameters:
- `NUM_STRIPS`, 8: parallel strips; width of `data_out`.
- `BITS_PER_LED`, 24: colour bits per LED, sent MSB first.
- `CLKS_PER_SYMBOL`, 24: `sr_clk` cycles per LED bit (3 phases × 8 shifts).
- `LATCH_SYMBOLS`, 48: blank symbols after a frame. This is 57.6 µs at 20 MHz, which meets the ≥50 µs requirement.

Ports:
- `sr_clk`, input, 1: the single clock for the block. All logic is on its rising edge.
- `ar`, input, 1: asynchronous reset, active low.
- `pix_data`, input, NUM_STRIPS*BITS_PER_LED: strip s uses bits [s*24+23 : s*24].
- `pix_last`, input, 1: qualifies `pix_data`; this is the last LED of the frame.
- `pix_valid`, input, 1: upstream has a pixel.
- `pix_ready`, output, 1: the block accepts the pixel on this edge.
- `data_out`, output, NUM_STRIPS: current bit for each strip.
- `blank`, output, 1: the top level must hold `ser_out` low (latch or idle).
- `frame_done`, output, 1: one-cycle pulse at the end of the latch period.
- `underrun`, output, 1: sticky flag; a mid-frame pixel was not available in time.

## Operation

- Symbol counter `sym_cnt` runs 0..CLKS_PER_SYMBOL-1 from reset release and wraps freely. `boundary` = (`sym_cnt` == CLKS_PER_SYMBOL-1).
  - The controller's phase counter uses the same `ar`, so the two stay aligned.
- Pixel buffer has 2 entries: an active shift word and one holding word.
  - `pix_ready` = holding empty, or holding being moved into active on this edge.
  - Transfer happens when `pix_valid && pix_ready`. A `pix_valid` with `pix_ready` low is held off with no loss.
- States. All transitions occur only on `boundary`.
  - IDLE: `blank`=1, `data_out`=0. If holding is full, load active, set `bit_idx`=BITS_PER_LED-1, go to SHIFT.
  - SHIFT: `blank`=0. `data_out[s]` = active[s*24 + `bit_idx`]. `bit_idx` decrements each boundary. When `bit_idx`=0:
    - if active was last → LATCH with `lat_cnt`=0;
    - else if holding is full → load the next pixel and stay in SHIFT;
    - else set `underrun` and go to IDLE.
  - LATCH: `blank`=1, `data_out`=0. `lat_cnt` increments each boundary. At `lat_cnt`=LATCH_SYMBOLS-1 → IDLE and pulse `frame_done` on that cycle.
- Pixels accepted during LATCH wait in holding. The next frame starts only after LATCH completes.
- `underrun` clears only on `ar`.
- A pixel with `pix_last`=1 and LATCH_SYMBOLS=0 is not supported; LATCH_SYMBOLS must be ≥1.

## Timing

- Reset values:
  - `data_out`=0, `blank`=1, `pix_ready`=1, `frame_done`=0, `underrun`=0.
  - State is IDLE; `sym_cnt`, `bit_idx`, `lat_cnt` are 0; both buffer entries are empty.
- Reset mid-frame discards all buffered pixels immediately (asynchronously). Outputs return to their reset values in the same instant.
- `data_out` and `blank` change only on the edge that ends a symbol (`sym_cnt` 23→0). They are stable for exactly CLKS_PER_SYMBOL cycles.
- Latency:
  - A pixel accepted in IDLE appears at the next symbol start: at most 24 cycles, at least 1.
  - A pixel stream with back-to-back LEDs has zero gap symbols.
- `pix_ready` deasserts the cycle after holding fills. It reasserts combinationally on the boundary edge where holding moves into active.
- Simultaneous events:
  - Accept and move on the same edge: the new pixel lands in holding. No loss, no duplication.
  - Last-bit boundary with holding filling on that same edge counts as available: no underrun.

## Structure

- Shared package `led_pkg`:
  - constants NUM_STRIPS, BITS_PER_LED, CLKS_PER_SYMBOL, LATCH_SYMBOLS;
  - state encoding IDLE=2'b00, SHIFT=2'b01, LATCH=2'b10, which the controller also uses for its phase encoding.
- One sub-module, `led_pix_buf`: the 2-entry buffer with valid/ready, `pix_last` carried alongside the data, and a `pop` input driven by the FSM on load boundaries.
- Counters (`sym_cnt`, `bit_idx`, `lat_cnt`) and the FSM live in the top.

## Test plan

- Reset, then idle for 100 cycles → `blank`=1, `data_out`=0, `pix_ready`=1, `frame_done` never pulses.
- One LED, all strips 0xA5_00_FF, `pix_last`=1 → 24 symbols of `data_out`=8'hFF/00 following the bits 1010_0101_0000_0000_1111_1111. Then 48 blank symbols, then `frame_done` pulses once, 24×(24+48) cycles after the first symbol start.
- 4 LEDs sent back-to-back, strip s = s×0x010101 → no gap symbols, per-strip bits correct, `underrun`=0.
- Upstream withholds LED 2 until 30 cycles after LED 1's last boundary → `underrun`=1, IDLE `blank` symbols, then resume; `underrun` stays 1 until `ar`.
- Pixel offered during LATCH → `pix_ready` accepts one and then drops. Shifting starts exactly at the boundary after `frame_done`.
- `ar` pulsed low mid-symbol during SHIFT → immediate reset values. The next pixel starts cleanly at `sym_cnt` 0 alignment after release.
